// File: rtl/mem_access.sv
// mem_access: data-cache request/response control, store lane/strobe build and load extraction.
// Optional MEM_LWLR_EN adds unaligned LWL/LWR word merges.
module mem_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
`ifdef MEM_LWLR_EN
    input  logic              mem_lwl,
    input  logic              mem_lwr,
    input  logic [DATA_W-1:0] mem_old_rt,
`endif
    input  logic              stall_in,
    input  logic              flush,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [1:0]        dreq_size,
    output logic [3:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              d_wait,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_done
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, DRAIN} state_t;
    state_t state, state_nx;
    logic killed, killed_nx, issue, complete, idle;
    logic [ADDR_W-1:0] addr_q, a, req_addr;
    logic [1:0] size_q, sz, req_size;
    logic signed_q, sg, write_q, wr;
    logic [DATA_W-1:0] wdata_q, wd, ext, ld, rdata_q;
    logic [7:0] b;
    logic [15:0] h;
    logic [3:0] strb;

    // Request fields come live from execute at issue, then from the captured copy so a
    // flushed op still holds a stable request until the cache accepts it.
    assign idle  = state == IDLE;
    assign a     = idle ? mem_addr   : addr_q;
    assign sz    = idle ? mem_size   : size_q;
    assign sg    = idle ? mem_signed : signed_q;
    assign wr    = idle ? mem_write  : write_q;
    assign wd    = idle ? mem_wdata  : wdata_q;
    assign issue = idle && mem_valid && !flush;

    assign b    = dresp_data[{a[1:0], 3'b000} +: 8];
    assign h    = a[1] ? dresp_data[31:16] : dresp_data[15:0];
    assign ext  = sz == 2'd0 ? {{24{sg & b[7]}}, b} :
                  sz == 2'd1 ? {{16{sg & h[15]}}, h} : dresp_data;
    assign strb = !wr ? 4'b0000 :
                  sz == 2'd0 ? 4'b0001 << a[1:0] :
                  sz == 2'd1 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;

`ifdef MEM_LWLR_EN
    logic lwl_q, lwr_q, lwl, lwr;
    assign lwl      = idle ? mem_lwl : lwl_q;
    assign lwr      = idle ? mem_lwr : lwr_q;
    assign req_addr = (lwl || lwr) ? {a[ADDR_W-1:2], 2'b00} : a;
    assign req_size = (lwl || lwr) ? 2'd2 : sz;
    assign ld = lwl ? (a[1:0] == 2'd0 ? {dresp_data[7:0], mem_old_rt[23:0]} :
                       a[1:0] == 2'd1 ? {dresp_data[15:0], mem_old_rt[15:0]} :
                       a[1:0] == 2'd2 ? {dresp_data[23:0], mem_old_rt[7:0]} : dresp_data) :
                lwr ? (a[1:0] == 2'd0 ? dresp_data :
                       a[1:0] == 2'd1 ? {mem_old_rt[31:24], dresp_data[31:8]} :
                       a[1:0] == 2'd2 ? {mem_old_rt[31:16], dresp_data[31:16]} :
                                        {mem_old_rt[31:8], dresp_data[31:24]}) : ext;
    always_ff @(posedge clk)
        if (reset) {lwl_q, lwr_q} <= 2'b00;
        else if (issue) {lwl_q, lwr_q} <= {mem_lwl, mem_lwr};
`else
    assign req_addr = a;
    assign req_size = sz;
    assign ld       = ext;
`endif

    always_comb begin
        state_nx  = state;
        killed_nx = killed;
        complete  = 1'b0;
        case (state)
            IDLE: if (issue) begin
                killed_nx = 1'b0;
                if (dresp_addr_ok && dresp_data_ok) complete = 1'b1;
                else state_nx = dresp_addr_ok ? DATA : ADDR;
            end
            ADDR: if (flush || killed) begin
                killed_nx = 1'b1;
                if (dresp_addr_ok) state_nx = dresp_data_ok ? IDLE : DRAIN;
            end else if (dresp_addr_ok && dresp_data_ok) complete = 1'b1;
            else if (dresp_addr_ok) state_nx = DATA;
            DATA: if (flush) state_nx = dresp_data_ok ? IDLE : DRAIN;
            else if (dresp_data_ok) complete = 1'b1;
            DONE: if (flush || !stall_in) state_nx = IDLE;
            DRAIN: if (dresp_data_ok) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (complete) state_nx = stall_in ? DONE : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            killed   <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state  <= state_nx;
            killed <= killed_nx;
            if (issue) begin
                addr_q   <= mem_addr;
                size_q   <= mem_size;
                signed_q <= mem_signed;
                write_q  <= mem_write;
                wdata_q  <= mem_wdata;
            end
            if (complete) rdata_q <= ld;
        end
    end

    assign dreq_valid  = issue || state == ADDR;
    assign dreq_addr   = dreq_valid ? req_addr : '0;
    assign dreq_size   = dreq_valid ? req_size : 2'd0;
    assign dreq_strobe = dreq_valid ? strb : 4'b0000;
    assign dreq_data   = !dreq_valid ? '0 :
                         sz == 2'd0 ? {4{wd[7:0]}} :
                         sz == 2'd1 ? {2{wd[15:0]}} : wd;
    assign out_done    = complete || state == DONE;
    assign out_rdata   = state == DONE ? rdata_q : complete ? ld : '0;
    assign d_wait      = state == DONE ? 1'b0 : state == DRAIN ? mem_valid : mem_valid && !out_done;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed and randomized checks of mem_access against a byte-lane reference model.
module tb_mem_access;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, mem_valid, mem_write, mem_signed, stall_in, flush;
    logic dresp_addr_ok, dresp_data_ok, dreq_valid, d_wait, out_done;
    logic [1:0] mem_size, dreq_size;
    logic [3:0] dreq_strobe;
    logic [31:0] mem_addr, mem_wdata, dresp_data, dreq_addr, dreq_data, out_rdata;
`ifdef MEM_LWLR_EN
    logic mem_lwl, mem_lwr;
    logic [31:0] mem_old_rt;
`endif
    int n_chk = 0, n_fail = 0;

    mem_access dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_write(mem_write),
        .mem_size(mem_size), .mem_signed(mem_signed), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef MEM_LWLR_EN
        .mem_lwl(mem_lwl), .mem_lwr(mem_lwr), .mem_old_rt(mem_old_rt),
`endif
        .stall_in(stall_in), .flush(flush), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .d_wait(d_wait), .out_rdata(out_rdata), .out_done(out_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        mem_valid = 0; mem_write = 0; mem_size = 0; mem_signed = 0; mem_addr = 0; mem_wdata = 0;
        stall_in = 0; flush = 0; dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = $urandom;
`ifdef MEM_LWLR_EN
        mem_lwl = 0; mem_lwr = 0; mem_old_rt = 0;
`endif
    endtask

    // One op: addr_ok alat cycles after issue, data_ok dlat cycles after addr_ok, stall_in held stl cycles from completion.
    task automatic run_op(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int alat, input int dlat, input int stl);
        int nb, off, d, hs;
        logic [3:0] es;
        logic [31:0] ed, er, msk;
        nb = 1 << sz; off = int'(a[1:0]); d = alat + dlat; hs = 0;
        for (int i = 0; i < 4; i++) begin
            es[i] = w && i >= off && i < off + nb;
            ed[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        msk = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
        er = (rd >> (8 * off)) & msk;
        if (sg && er[8*nb-1]) er = er | ~msk;
        mem_valid = 1; mem_write = w; mem_size = sz; mem_signed = sg; mem_addr = a; mem_wdata = wd;
        for (int c = 0; c <= d + stl; c++) begin
            dresp_addr_ok = (c == alat);
            dresp_data_ok = (c == d);
            dresp_data = (c == d) ? rd : $urandom;
            stall_in = (c >= d && c < d + stl);
            #1;
            if (dreq_valid && dresp_addr_ok) hs++;
            n_chk++;
            if (dreq_valid !== (c <= alat)) begin
                n_fail++; $display("FAIL op_req_valid cyc %0d: got %b want %b", c, dreq_valid, c <= alat);
            end
            if (c <= alat) begin
                n_chk++;
                if ({dreq_addr, dreq_size, dreq_strobe} !== {a, sz, es}) begin
                    n_fail++; $display("FAIL op_req_fields cyc %0d: got %h/%0d/%b want %h/%0d/%b", c, dreq_addr, dreq_size, dreq_strobe, a, sz, es);
                end
                if (w) begin
                    n_chk++;
                    if (dreq_data !== ed) begin
                        n_fail++; $display("FAIL op_req_data cyc %0d: got %h want %h", c, dreq_data, ed);
                    end
                end
            end
            n_chk++;
            if (out_done !== (c >= d)) begin
                n_fail++; $display("FAIL op_done cyc %0d: got %b want %b", c, out_done, c >= d);
            end
            n_chk++;
            if (d_wait !== (c < d)) begin
                n_fail++; $display("FAIL op_d_wait cyc %0d: got %b want %b", c, d_wait, c < d);
            end
            if (!w && c >= d) begin
                n_chk++;
                if (out_rdata !== er) begin
                    n_fail++; $display("FAIL op_rdata cyc %0d: got %h want %h", c, out_rdata, er);
                end
            end
            tick;
        end
        idle_inputs;
        #1;
        n_chk++;
        if (hs != 1 || out_done !== 1'b0) begin
            n_fail++; $display("FAIL op_end: handshakes %0d done %b want 1 and 0", hs, out_done);
        end
        tick;
    endtask

    task automatic test_reset;
        reset = 1; idle_inputs; tick; tick;
        reset = 0; #1;
        n_chk++;
        if ({dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data} !== '0) begin
            n_fail++; $display("FAIL reset_req: got v%b a%h s%0d b%b d%h want zeros", dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data);
        end
        n_chk++;
        if ({d_wait, out_done, out_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_out: got w%b d%b r%h want zeros", d_wait, out_done, out_rdata);
        end
        tick;
    endtask

    task automatic test_signed_byte;
        run_op(0, 2'd0, 1, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0, 0);
    endtask

    task automatic test_half_store;
        run_op(1, 2'd1, 0, 32'h2002, 32'h0000_ABCD, 32'h0, 3, 0, 0);
    endtask

    task automatic test_stall_done;
        run_op(0, 2'd2, 0, 32'h0000_0040, 32'h0, 32'h1234_5678, 0, 2, 4);
    endtask

    task automatic test_flush_drain;
        logic [31:0] v;
        v = $urandom;
        mem_valid = 1; mem_size = 2; mem_addr = 32'h100; dresp_addr_ok = 1;
        #1; n_chk++;
        if (dreq_valid !== 1'b1) begin n_fail++; $display("FAIL flush_issue: got %b want 1", dreq_valid); end
        tick;
        dresp_addr_ok = 0; flush = 1;
        #1; n_chk++;
        if ({dreq_valid, out_done} !== 2'b00) begin n_fail++; $display("FAIL flush_cycle: got v%b d%b want 0 0", dreq_valid, out_done); end
        tick;
        flush = 0; mem_addr = 32'h200;
        #1; n_chk++;
        if ({dreq_valid, d_wait} !== 2'b01) begin n_fail++; $display("FAIL drain_wait: got v%b w%b want 0 1", dreq_valid, d_wait); end
        tick;
        dresp_data_ok = 1; dresp_data = 32'hDEAD_BEEF;
        #1; n_chk++;
        if ({dreq_valid, out_done, d_wait} !== 3'b001) begin n_fail++; $display("FAIL drain_discard: got v%b d%b w%b want 0 0 1", dreq_valid, out_done, d_wait); end
        tick;
        dresp_data_ok = 0;
        #1; n_chk++;
        if (dreq_valid !== 1'b1 || dreq_addr !== 32'h200) begin n_fail++; $display("FAIL new_req: got v%b a%h want 1 00000200", dreq_valid, dreq_addr); end
        dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = v;
        #1; n_chk++;
        if (out_done !== 1'b1 || out_rdata !== v) begin n_fail++; $display("FAIL new_done: got d%b r%h want 1 %h", out_done, out_rdata, v); end
        tick;
        idle_inputs; tick;
    endtask

    task automatic test_reset_mid;
        mem_valid = 1; mem_write = 1; mem_size = 2; mem_addr = 32'h500; mem_wdata = $urandom;
        tick;
        #1; n_chk++;
        if (dreq_valid !== 1'b1 || dreq_addr !== 32'h500) begin n_fail++; $display("FAIL mid_addr_hold: got v%b a%h want 1 00000500", dreq_valid, dreq_addr); end
        reset = 1; tick;
        reset = 0; idle_inputs; dresp_data_ok = 1;
        #1; n_chk++;
        if ({dreq_valid, dreq_addr, dreq_strobe, dreq_data} !== '0) begin n_fail++; $display("FAIL mid_reset_req: got v%b a%h b%b d%h want zeros", dreq_valid, dreq_addr, dreq_strobe, dreq_data); end
        n_chk++;
        if ({d_wait, out_done, out_rdata} !== '0) begin n_fail++; $display("FAIL mid_reset_out: got w%b d%b r%h want zeros", d_wait, out_done, out_rdata); end
        tick;
        dresp_data_ok = 0;
        run_op(0, 2'd1, 1, 32'h0000_0602, 32'h0, 32'h8001_7FFF, 1, 1, 0);
    endtask

    task automatic test_random;
        logic [1:0] sz;
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            sz = 2'($urandom_range(0, 2));
            a = $urandom & ~((32'h1 << sz) - 32'h1);
            run_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

`ifdef MEM_LWLR_EN
    task automatic test_lwlr;
        mem_valid = 1; mem_lwl = 1; mem_size = 2; mem_addr = 32'h3001; mem_old_rt = 32'hAAAA_BBBB;
        dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 32'h4433_2211;
        #1; n_chk++;
        if (dreq_addr !== 32'h3000 || dreq_size !== 2'd2 || dreq_strobe !== 4'b0000) begin n_fail++; $display("FAIL lwl_req: got a%h s%0d b%b want 00003000 2 0000", dreq_addr, dreq_size, dreq_strobe); end
        n_chk++;
        if (out_done !== 1'b1 || out_rdata !== 32'h2211_BBBB) begin n_fail++; $display("FAIL lwl_data: got d%b r%h want 1 2211bbbb", out_done, out_rdata); end
        tick;
        mem_lwl = 0; mem_lwr = 1; mem_addr = 32'h3002;
        #1; n_chk++;
        if (out_rdata !== 32'hAAAA_4433) begin n_fail++; $display("FAIL lwr_data: got %h want aaaa4433", out_rdata); end
        tick;
        idle_inputs; tick;
    endtask
`endif

    initial begin
        test_reset;
        test_signed_byte;
        test_half_store;
        test_stall_done;
        test_flush_drain;
        test_reset_mid;
        test_random;
`ifdef MEM_LWLR_EN
        test_lwlr;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access control stage sitting directly downstream of the dual-issue execute stage. It takes the single memory operation selected from the execute bundle (effective address, store data, size, signedness), runs the request/response handshake with the data cache, and builds byte strobes and store-data lanes. It also extracts and sign/zero-extends load data. It owns the `d_wait` stall fed back to execute and holds a completed result while the pipeline is stalled by another source.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; fixed at 32, other values unsupported

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous reset, active-high
- `mem_valid`  in  1  memory op present; inputs stable while `d_wait` or `stall_in`
- `mem_write`  in  1  1 = store, 0 = load
- `mem_size`  in  2  0 byte, 1 half, 2 word
- `mem_signed`  in  1  sign-extend load result
- `mem_addr`  in  ADDR_W  effective address (execute ALU output)
- `mem_wdata`  in  DATA_W  store data (execute srcb)
- `mem_lwl`, `mem_lwr`  in  1 each  present only with `MEM_LWLR_EN`
- `mem_old_rt`  in  DATA_W  present only with `MEM_LWLR_EN`; current rt for merge
- `stall_in`  in  1  downstream/other stall; the bundle does not advance
- `flush`  in  1  kill the current op (exception/redirect)
- `dreq_valid`  out  1  cache request
- `dreq_addr`  out  ADDR_W  request address
- `dreq_size`  out  2  request size
- `dreq_strobe`  out  4  byte enables; 0 for loads
- `dreq_data`  out  DATA_W  lane-replicated store data
- `dresp_addr_ok`  in  1  request accepted
- `dresp_data_ok`  in  1  response/write-ack
- `dresp_data`  in  DATA_W  load word
- `d_wait`  out  1  stall to execute
- `out_rdata`  out  DATA_W  extracted load result
- `out_done`  out  1  op complete this cycle

## Operation
- States: IDLE, ADDR, DATA, DONE, DRAIN. Reset → IDLE; all outputs 0.
- `dreq_*` are combinational from inputs in IDLE/ADDR; `dreq_valid` = `mem_valid && !flush` in IDLE, 1 in ADDR, 0 elsewhere.
- Once raised, `dreq_valid` stays high with stable fields until `dresp_addr_ok`.
- IDLE: if `mem_valid && !flush`: addr_ok&&data_ok → complete; addr_ok only → DATA; else → ADDR.
- ADDR: addr_ok&&data_ok → complete; addr_ok → DATA.
- DATA: data_ok → complete.
- Complete: `out_done`=1, `out_rdata` from `dresp_data`, and the result is latched. Next state is DONE if `stall_in`, else IDLE.
- DONE: `out_done`=1, `out_rdata` = latched value, no new request. Leaves for IDLE in the first cycle with `!stall_in`.
- `d_wait` = `mem_valid && !out_done` in IDLE/ADDR/DATA; 1 in DRAIN when `mem_valid`; 0 in DONE.
- Flush:
  - IDLE/DONE → IDLE.
  - ADDR → keep the request until addr_ok, then DRAIN. If data_ok arrives in the same cycle, go to IDLE.
  - DATA → DRAIN.
- DRAIN waits for data_ok, discards the data and issues nothing, then goes to IDLE.
- Strobes:
  - byte: `0001<<a[1:0]`, data `{4{wdata[7:0]}}`.
  - half: `0011<<{a[1],0}`, data `{2{wdata[15:0]}}`.
  - word: `1111`.
- Load extract: shift `dresp_data` right by `8*a[1:0]`, then mask to size. Sign-extend if `mem_signed`, else zero-extend.
- Misaligned ops never arrive; execute clears memtoreg/memwrite for them.

## Timing
- Best case (addr_ok and data_ok in issue cycle): 0 stall cycles, `out_done` in the issue cycle.
- Otherwise: stall cycles = cycles until data_ok. `d_wait` falls combinationally in the data_ok cycle.
- One outstanding request maximum; no new request is issued in DATA or DRAIN.
- `reset` mid-transaction → IDLE next cycle. A late response after reset is ignored (DRAIN is not entered).

## Configuration
- `MEM_LWLR_EN` defined: adds `mem_lwl`/`mem_lwr`/`mem_old_rt`.
  - Request is word-aligned (`a & ~3`), size word.
  - LWL merge for a[1:0] = 0/1/2/3: `{m[7:0],rt[23:0]}`, `{m[15:0],rt[15:0]}`, `{m[23:0],rt[7:0]}`, `m`.
  - LWR merge for a[1:0] = 0/1/2/3: `m`, `{rt[31:24],m[31:8]}`, `{rt[31:16],m[31:16]}`, `{rt[31:8],m[31:24]}`.
- Undefined: those ports are absent; only aligned byte/half/word accesses are supported.

## Test plan
- Signed byte load at 0x1003, cache returns 0x80FF_1234 with addr_ok+data_ok in the same cycle → `out_rdata`=0xFFFF_FF80, `d_wait` never high.
- Half store of 0xABCD at 0x2002, addr_ok after 3 cycles → `dreq_valid` held 3 cycles with strobe 1100 and data 0xABCD_ABCD; `d_wait` high until data_ok.
- Unsigned word load, data_ok 2 cycles after addr_ok with `stall_in` high 4 more cycles → DONE holds 0x1234_5678, exactly one request issued.
- `flush` in DATA, then a new load presented → no request until the stale data_ok is discarded; the new request is issued the cycle after.
- `reset` asserted in ADDR → next cycle all outputs 0, state IDLE.
- With `MEM_LWLR_EN`: LWL at 0x3001, mem 0x4433_2211, rt 0xAAAA_BBBB → `out_rdata`=0x2211_BBBB, `dreq_addr`=0x3000.
